// File: rtl/riscv_pkg.sv
// Shared RISC-V writeback definitions: default widths, the x0 register index
// and the writeback arbiter state encoding.
package riscv_pkg;

  localparam int DWIDTH_DEF = 64;
  localparam int AWIDTH_DEF = 5;
  localparam int REG_X0     = 0;

  typedef enum logic {
    CORE_PRI  = 1'b0,
    ACC_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular-buffer FIFO with wrap-around pointers. The head entry
// is read combinationally from storage; there is no write-to-read bypass.
module wb_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even if an entry is leaving in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: core results take priority, accelerator
// results queue in a FIFO and are forced through after STARVE_MAX core grants.
// Define WB_BYPASS_EN to add the rs1/rs2 forwarding ports.
module reg_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int AWIDTH     = AWIDTH_DEF,
  parameter int ACC_DEPTH  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       core_valid,
  output logic                       core_ready,
  input  logic [AWIDTH-1:0]          core_rd,
  input  logic [DWIDTH-1:0]          core_data,
  input  logic                       acc_valid,
  output logic                       acc_ready,
  input  logic [AWIDTH-1:0]          acc_rd,
  input  logic [DWIDTH-1:0]          acc_data,
  output logic                       wb_we,
  output logic [AWIDTH-1:0]          wb_addr,
  output logic [DWIDTH-1:0]          wb_data,
  output logic [$clog2(ACC_DEPTH):0] fifo_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [AWIDTH-1:0]          rs1_addr,
  input  logic [AWIDTH-1:0]          rs2_addr,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [DWIDTH-1:0]          fwd1_data,
  output logic [DWIDTH-1:0]          fwd2_data
`endif
);

  localparam int EW = AWIDTH + DWIDTH;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q;
  logic [SW-1:0]     starve_q;
  logic              wb_we_q;
  logic [AWIDTH-1:0] wb_addr_q;
  logic [DWIDTH-1:0] wb_data_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [AWIDTH-1:0] head_rd;
  logic [DWIDTH-1:0] head_data;
  logic              core_win;
  logic              acc_win;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (ACC_DEPTH)
  ) u_acc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (acc_valid),
    .pop_i   (acc_win),
    .wdata_i ({acc_rd, acc_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_rd    = fifo_head[EW-1:DWIDTH];
  assign head_data  = fifo_head[DWIDTH-1:0];
  assign acc_ready  = !fifo_full;
  assign core_ready = (state_q == CORE_PRI);

  always_comb begin
    core_win = 1'b0;
    acc_win  = 1'b0;
    if (state_q == CORE_PRI) begin
      core_win = core_valid;
      acc_win  = !core_valid && !fifo_empty;
    end else begin
      acc_win  = !fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CORE_PRI;
      starve_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      // x0 results are consumed but never reach the register file.
      if (core_win) begin
        wb_we_q   <= (core_rd != AWIDTH'(REG_X0));
        wb_addr_q <= core_rd;
        wb_data_q <= core_data;
      end else if (acc_win) begin
        wb_we_q   <= (head_rd != AWIDTH'(REG_X0));
        wb_addr_q <= head_rd;
        wb_data_q <= head_data;
      end else begin
        wb_we_q   <= 1'b0;
      end

      case (state_q)
        CORE_PRI: begin
          if (core_win && !fifo_empty) begin
            starve_q <= starve_q + SW'(1);
            if (starve_q == SW'(STARVE_MAX - 1)) begin
              state_q <= ACC_FORCE;
            end
          end else begin
            starve_q <= '0;
          end
        end
        ACC_FORCE: begin
          starve_q <= '0;
          state_q  <= CORE_PRI;
        end
      endcase
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

`ifdef WB_BYPASS_EN
  // The register file returns stale data on a same-cycle read/write.
  assign fwd1_hit  = wb_we_q && (rs1_addr == wb_addr_q) && (rs1_addr != AWIDTH'(REG_X0));
  assign fwd2_hit  = wb_we_q && (rs2_addr == wb_addr_q) && (rs2_addr != AWIDTH'(REG_X0));
  assign fwd1_data = wb_data_q;
  assign fwd2_data = wb_data_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed-vector bench for reg_wb_arbiter: reset, core writes, x0 drops,
// starvation forcing, FIFO wrap ordering, optional forwarding, mid-run reset.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_valid = 1'b0;
  logic        core_ready;
  logic [4:0]  core_rd = '0;
  logic [63:0] core_data = '0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [4:0]  acc_rd = '0;
  logic [63:0] acc_data = '0;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [63:0] fwd1_data;
  logic [63:0] fwd2_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .core_rd    (core_rd),
    .core_data  (core_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_rd     (acc_rd),
    .acc_data   (acc_data),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .fifo_count (fifo_count)
`ifdef WB_BYPASS_EN
    ,
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b want 0", wb_we); end
    n_vec++; if (wb_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", wb_addr); end
    n_vec++; if (wb_data !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", wb_data); end
    n_vec++; if (acc_ready !== 1'b1) begin n_err++; $display("FAIL reset_acc_ready: got %0b want 1", acc_ready); end
    n_vec++; if (core_ready !== 1'b1) begin n_err++; $display("FAIL reset_core_ready: got %0b want 1", core_ready); end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    rst_n = 1'b1;
    step();
    n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL idle_we: got %0b want 0", wb_we); end
    $display("reset: released, idle");
  endtask

  task automatic test_core_write();
    core_valid = 1'b1; core_rd = 5'd5; core_data = 64'hDEADBEEF_00000001;
    n_vec++; if (core_ready !== 1'b1) begin n_err++; $display("FAIL cw_ready: got %0b want 1", core_ready); end
    step();
    core_valid = 1'b0;
    n_vec++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL cw_we: got %0b want 1", wb_we); end
    n_vec++; if (wb_addr !== 5'd5) begin n_err++; $display("FAIL cw_addr: got %0d want 5", wb_addr); end
    n_vec++; if (wb_data !== 64'hDEADBEEF_00000001) begin n_err++; $display("FAIL cw_data: got %h want deadbeef00000001", wb_data); end
    step();
    n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL cw_we_after: got %0b want 0", wb_we); end
    n_vec++; if (wb_addr !== 5'd5) begin n_err++; $display("FAIL cw_addr_hold: got %0d want 5", wb_addr); end
    $display("core write: rd=5 data=deadbeef00000001");
  endtask

  task automatic test_x0_drop();
    core_valid = 1'b1; core_rd = 5'd0; core_data = 64'hAAAA;
    step();
    core_valid = 1'b0;
    n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL x0core_we: got %0b want 0", wb_we); end
    n_vec++; if (wb_addr !== 5'd0) begin n_err++; $display("FAIL x0core_addr: got %0d want 0", wb_addr); end
    n_vec++; if (wb_data !== 64'hAAAA) begin n_err++; $display("FAIL x0core_data: got %h want aaaa", wb_data); end
    $display("x0 write: core rd=0 data=aaaa");
    acc_valid = 1'b1; acc_rd = 5'd0; acc_data = 64'hBBBB;
    step();
    acc_valid = 1'b0;
    n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL x0acc_count1: got %0d want 1", fifo_count); end
    step();
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL x0acc_count0: got %0d want 0", fifo_count); end
    n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL x0acc_we: got %0b want 0", wb_we); end
    n_vec++; if (wb_data !== 64'hBBBB) begin n_err++; $display("FAIL x0acc_data: got %h want bbbb", wb_data); end
    $display("x0 write: acc rd=0 data=bbbb");
  endtask

  task automatic test_starvation();
    core_valid = 1'b1; core_rd = 5'd10; core_data = 64'hC0C0;
    for (int i = 0; i < 4; i++) begin
      acc_valid = 1'b1; acc_rd = 5'(i + 1); acc_data = 64'h100 + 64'(i);
      n_vec++; if (acc_ready !== 1'b1) begin n_err++; $display("FAIL st_acc_ready%0d: got %0b want 1", i, acc_ready); end
      step();
      $display("acc push: rd=%0d data=%h", i + 1, 64'h100 + 64'(i));
    end
    acc_valid = 1'b0;
    n_vec++; if (acc_ready !== 1'b0) begin n_err++; $display("FAIL st_full_ready: got %0b want 0", acc_ready); end
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL st_full_count: got %0d want 4", fifo_count); end
    // Three core grants with a non-empty FIFO so far; five more reach the limit.
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (core_ready !== 1'b1) begin n_err++; $display("FAIL st_core_ready%0d: got %0b want 1", i, core_ready); end
      step();
    end
    n_vec++; if (core_ready !== 1'b0) begin n_err++; $display("FAIL st_force: got %0b want 0", core_ready); end
    n_vec++; if (wb_addr !== 5'd10) begin n_err++; $display("FAIL st_last_core: got %0d want 10", wb_addr); end
    step();
    n_vec++; if (core_ready !== 1'b1) begin n_err++; $display("FAIL st_force_end: got %0b want 1", core_ready); end
    n_vec++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL st_acc_we: got %0b want 1", wb_we); end
    n_vec++; if (wb_addr !== 5'd1) begin n_err++; $display("FAIL st_acc_addr: got %0d want 1", wb_addr); end
    n_vec++; if (wb_data !== 64'h100) begin n_err++; $display("FAIL st_acc_data: got %h want 100", wb_data); end
    n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL st_acc_count: got %0d want 3", fifo_count); end
    $display("forced acc write: rd=1 data=100");
    step();
    core_valid = 1'b0;
    n_vec++; if (wb_addr !== 5'd10) begin n_err++; $display("FAIL st_core_back: got %0d want 10", wb_addr); end
    for (int i = 1; i < 4; i++) begin
      step();
      n_vec++; if (wb_addr !== 5'(i + 1)) begin n_err++; $display("FAIL st_drain_addr%0d: got %0d want %0d", i, wb_addr, i + 1); end
      n_vec++; if (wb_data !== 64'h100 + 64'(i)) begin n_err++; $display("FAIL st_drain_data%0d: got %h want %h", i, wb_data, 64'h100 + 64'(i)); end
      $display("acc drain: rd=%0d data=%h", wb_addr, wb_data);
    end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL st_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_wrap_order();
    core_valid = 1'b1; core_rd = 5'd11; core_data = 64'hD0D0;
    for (int i = 0; i < 2; i++) begin
      acc_valid = 1'b1; acc_rd = 5'(16 + i); acc_data = 64'h200 + 64'(i);
      step();
    end
    core_valid = 1'b0;
    n_vec++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL wr_count2: got %0d want 2", fifo_count); end
    for (int i = 2; i < 6; i++) begin
      acc_rd = 5'(16 + i); acc_data = 64'h200 + 64'(i);
      step();
      n_vec++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL wr_pushpop_count%0d: got %0d want 2", i, fifo_count); end
      n_vec++; if (wb_data !== 64'h200 + 64'(i - 2)) begin n_err++; $display("FAIL wr_order%0d: got %h want %h", i, wb_data, 64'h200 + 64'(i - 2)); end
      $display("push/pop: in=%h out=%h", 64'h200 + 64'(i), wb_data);
    end
    acc_valid = 1'b0;
    for (int i = 4; i < 6; i++) begin
      step();
      n_vec++; if (wb_addr !== 5'(16 + i)) begin n_err++; $display("FAIL wr_tail_addr%0d: got %0d want %0d", i, wb_addr, 16 + i); end
      n_vec++; if (wb_data !== 64'h200 + 64'(i)) begin n_err++; $display("FAIL wr_tail_data%0d: got %h want %h", i, wb_data, 64'h200 + 64'(i)); end
    end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL wr_empty: got %0d want 0", fifo_count); end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    core_valid = 1'b1; core_rd = 5'd7; core_data = 64'h1234;
    step();
    core_valid = 1'b0;
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    #1;
    n_vec++; if (fwd1_hit !== 1'b1) begin n_err++; $display("FAIL bp_hit1: got %0b want 1", fwd1_hit); end
    n_vec++; if (fwd1_data !== 64'h1234) begin n_err++; $display("FAIL bp_data1: got %h want 1234", fwd1_data); end
    n_vec++; if (fwd2_hit !== 1'b0) begin n_err++; $display("FAIL bp_hit2: got %0b want 0", fwd2_hit); end
    step();
    n_vec++; if (fwd1_hit !== 1'b0) begin n_err++; $display("FAIL bp_hit1_idle: got %0b want 0", fwd1_hit); end
    rs1_addr = 5'd0;
    $display("bypass: rd=7 data=1234 forwarded");
  endtask
`endif

  task automatic test_reset_mid();
    core_valid = 1'b1; core_rd = 5'd12; core_data = 64'hE0E0;
    for (int i = 0; i < 3; i++) begin
      acc_valid = 1'b1; acc_rd = 5'(20 + i); acc_data = 64'h300 + 64'(i);
      step();
    end
    acc_valid = 1'b0; core_valid = 1'b0;
    n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL rm_pre_count: got %0d want 3", fifo_count); end
    n_vec++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL rm_pre_we: got %0b want 1", wb_we); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
    n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL rm_we: got %0b want 0", wb_we); end
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL rm_stale_we%0d: got %0b want 0", i, wb_we); end
    end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rm_post_count: got %0d want 0", fifo_count); end
    $display("mid-run reset: fifo flushed, no stale write");
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_x0_drop();
    test_starvation();
    test_wrap_order();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
